// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared opcode/state types and widths for reg_file_arbiter
package rf_arb_pkg;

    localparam int OP_W    = 2;
    localparam int STATE_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_SWAP = 2'b11
    } op_t;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_WR       = 3'd2,
        S_NOP      = 3'd3,
        S_SW_START = 3'd4,
        S_SW_WAIT  = 3'd5
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, search starts just above ptr
// Ports: req (N) request vector, ptr last winner index,
//        grant one-hot winner, winner index, any = some request present.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner,
    output logic             any
);

    int idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        // k = N wraps back to ptr itself, so the last winner is considered last.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any         = 1'b1;
                grant[idx]  = 1'b1;
                winner      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// rtl/reg_file_arbiter.sv - round-robin sequencer sharing one swap-capable register file
// Ports: clk, reset_n (async active-low); per-requester req/op/addr_a/addr_b/wdata in,
//        gnt (comb one-hot accept), done (registered one-hot), rdata, busy out;
//        rf_we/rf_addr_w/rf_data_w write port, rf_addr_r/rf_data_r read port,
//        rf_swap/rf_addr_a/rf_addr_b swap port.
// Option macro RF_ARB_ERR_EN: adds err output; equal-address swap is rejected as a NOP with err.
module reg_file_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N           = 4,
    parameter int addr_width  = 7,
    parameter int data_width  = 8,
    parameter int SWAP_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N-1:0]            req,
    input  logic [2*N-1:0]          op,
    input  logic [N*addr_width-1:0] addr_a,
    input  logic [N*addr_width-1:0] addr_b,
    input  logic [N*data_width-1:0] wdata,
    output logic [N-1:0]            gnt,
    output logic [N-1:0]            done,
    output logic [data_width-1:0]   rdata,
    output logic                    busy,
`ifdef RF_ARB_ERR_EN
    output logic                    err,
`endif
    output logic                    rf_we,
    output logic [addr_width-1:0]   rf_addr_w,
    output logic [addr_width-1:0]   rf_addr_r,
    output logic [data_width-1:0]   rf_data_w,
    input  logic [data_width-1:0]   rf_data_r,
    output logic                    rf_swap,
    output logic [addr_width-1:0]   rf_addr_a,
    output logic [addr_width-1:0]   rf_addr_b
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(SWAP_CYCLES + 1);

    state_t                 state;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       owner;
    logic [CNT_W-1:0]       cnt;
    logic [N-1:0]           arb_grant;
    logic [IDX_W-1:0]       arb_winner;
    logic                   arb_any;
    op_t                    sel_op;
    logic [addr_width-1:0]  sel_a;
    logic [addr_width-1:0]  sel_b;
    logic [data_width-1:0]  sel_wd;
    logic                   exec_last;
`ifdef RF_ARB_ERR_EN
    logic                   err_pend;
`endif

    rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_rr (
        .req    (req),
        .ptr    (ptr),
        .grant  (arb_grant),
        .winner (arb_winner),
        .any    (arb_any)
    );

    // Grants only exist in IDLE; gating with reset_n keeps gnt quiet while held in reset.
    assign gnt = (state == S_IDLE && reset_n) ? arb_grant : '0;

    always_comb begin
        sel_op = OP_NOP;
        sel_a  = '0;
        sel_b  = '0;
        sel_wd = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_grant[i]) begin
                sel_op = op_t'(op[i*OP_W +: OP_W]);
                sel_a  = addr_a[i*addr_width +: addr_width];
                sel_b  = addr_b[i*addr_width +: addr_width];
                sel_wd = wdata[i*data_width +: data_width];
            end
        end
    end

    // Final cycle of the executing command: done is registered on this edge.
    always_comb begin
        exec_last = 1'b0;
        case (state)
            S_RD, S_WR, S_NOP: exec_last = 1'b1;
            S_SW_START:        exec_last = (SWAP_CYCLES <= 1);
            S_SW_WAIT:         exec_last = (cnt == CNT_W'(1));
            default:           exec_last = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ptr       <= IDX_W'(N - 1);
            owner     <= '0;
            cnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            rf_we     <= 1'b0;
            rf_addr_w <= '0;
            rf_addr_r <= '0;
            rf_data_w <= '0;
            rf_swap   <= 1'b0;
            rf_addr_a <= '0;
            rf_addr_b <= '0;
`ifdef RF_ARB_ERR_EN
            err       <= 1'b0;
            err_pend  <= 1'b0;
`endif
        end else begin
            done    <= '0;
            rf_we   <= 1'b0;
            rf_swap <= 1'b0;
`ifdef RF_ARB_ERR_EN
            err     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        ptr   <= arb_winner;
                        owner <= arb_winner;
                        busy  <= 1'b1;
                        // Port registers are loaded here so they are live during the exec cycle.
                        case (sel_op)
                            OP_RD: begin
                                rf_addr_r <= sel_a;
                                state     <= S_RD;
                            end
                            OP_WR: begin
                                rf_we     <= 1'b1;
                                rf_addr_w <= sel_a;
                                rf_data_w <= sel_wd;
                                state     <= S_WR;
                            end
                            OP_SWAP: begin
`ifdef RF_ARB_ERR_EN
                                if (sel_a == sel_b) begin
                                    err_pend <= 1'b1;
                                    state    <= S_NOP;
                                end else
`endif
                                begin
                                    rf_swap   <= 1'b1;
                                    rf_addr_a <= sel_a;
                                    rf_addr_b <= sel_b;
                                    state     <= S_SW_START;
                                end
                            end
                            default: state <= S_NOP;
                        endcase
                    end
                end
                S_RD:       rdata <= rf_data_r;
                S_SW_START: begin
                    if (SWAP_CYCLES > 1) begin
                        cnt   <= CNT_W'(SWAP_CYCLES - 1);
                        state <= S_SW_WAIT;
                    end
                end
                S_SW_WAIT:  cnt <= cnt - 1'b1;
                default:    ;
            endcase

            if (exec_last) begin
                done[owner] <= 1'b1;
                state       <= S_IDLE;
                busy        <= 1'b0;
`ifdef RF_ARB_ERR_EN
                err         <= err_pend;
                err_pend    <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb/tb_reg_file_arbiter.sv - directed scoreboard bench for reg_file_arbiter
module tb_reg_file_arbiter;
    import rf_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 7;
    localparam int DW = 8;
    localparam int SC = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [2*N-1:0]  op;
    logic [N*AW-1:0] addr_a, addr_b;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, done;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            rf_we, rf_swap;
    logic [AW-1:0]   rf_addr_w, rf_addr_r, rf_addr_a, rf_addr_b;
    logic [DW-1:0]   rf_data_w, rf_data_r;
`ifdef RF_ARB_ERR_EN
    logic            err;
`endif

    typedef struct {
        logic [N-1:0]  onehot;
        logic          is_rd;
        logic [DW-1:0] rd;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    reg_file_arbiter #(.N(N), .addr_width(AW), .data_width(DW), .SWAP_CYCLES(SC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .op        (op),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
`ifdef RF_ARB_ERR_EN
        .err       (err),
`endif
        .rf_we     (rf_we),
        .rf_addr_w (rf_addr_w),
        .rf_addr_r (rf_addr_r),
        .rf_data_w (rf_data_w),
        .rf_data_r (rf_data_r),
        .rf_swap   (rf_swap),
        .rf_addr_a (rf_addr_a),
        .rf_addr_b (rf_addr_b)
    );

    // Register file model
    assign rf_data_r = mem[rf_addr_r];
    always @(posedge clk) begin
        if (rf_we) mem[rf_addr_w] <= rf_data_w;
        else if (rf_swap) begin
            mem[rf_addr_a] <= mem[rf_addr_b];
            mem[rf_addr_b] <= mem[rf_addr_a];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int i, input op_t o, input logic [AW-1:0] a,
                           input logic [AW-1:0] b, input logic [DW-1:0] d);
        op[i*2 +: 2]      = o;
        addr_a[i*AW +: AW] = a;
        addr_b[i*AW +: AW] = b;
        wdata[i*DW +: DW]  = d;
    endtask

    task automatic push(input int i, input logic is_rd, input logic [DW-1:0] rd, input logic e);
        exp_t x;
        x.onehot = N'(1) << i;
        x.is_rd  = is_rd;
        x.rd     = rd;
        x.err    = e;
        sb.push_back(x);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(tag, sb.size(), 0);
    endtask

    // Completion monitor: every done pulse must match the oldest outstanding command.
    always @(negedge clk) begin
        if (reset_n && done != '0) begin
            if (sb.size() == 0) chk("done_unexpected", done, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_idx", done, e.onehot);
                if (e.is_rd) chk("rdata", rdata, e.rd);
`ifdef RF_ARB_ERR_EN
                chk("err", err, e.err);
`endif
            end
        end
        if (reset_n && (rf_we || rf_swap)) chk("we_swap_excl", rf_we & rf_swap, 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; req = '0; op = '0; addr_a = '0; addr_b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", gnt, 0);   chk("rst_done", done, 0);  chk("rst_busy", busy, 0);
        chk("rst_we", rf_we, 0);  chk("rst_swap", rf_swap, 0); chk("rst_rdata", rdata, 0);
        chk("rst_addr_a", rf_addr_a, 0); chk("rst_data_w", rf_data_w, 0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);

        // Test 1: WR a=5 d=A5 from requester 0
        set_cmd(0, OP_WR, 7'd5, 7'd0, 8'hA5); req = 4'b0001; #1;
        chk("t1_gnt", gnt, 4'b0001); push(0, 0, 0, 0);
        @(negedge clk); req = '0; #1;
        chk("t1_we", rf_we, 1); chk("t1_addr_w", rf_addr_w, 5); chk("t1_data_w", rf_data_w, 8'hA5);
        chk("t1_busy", busy, 1); chk("t1_done_early", done, 0);
        @(negedge clk); #1;
        chk("t1_done", done, 4'b0001); chk("t1_we_off", rf_we, 0); chk("t1_idle", busy, 0);

        // Test 2: RD a=5 returns A5
        set_cmd(0, OP_RD, 7'd5, 7'd0, 8'h00); req = 4'b0001; #1;
        chk("t2_gnt", gnt, 4'b0001); push(0, 1, 8'hA5, 0);
        @(negedge clk); req = '0; #1;
        chk("t2_addr_r", rf_addr_r, 5); chk("t2_we", rf_we, 0);
        @(negedge clk); #1;
        chk("t2_done", done, 4'b0001); chk("t2_rdata", rdata, 8'hA5);

        // Test 3: all four request WR; pointer sits at 0, so rotation runs 1,2,3,0,1
        for (int i = 0; i < N; i++) set_cmd(i, OP_WR, AW'(10 + i), 7'd0, DW'(8'h10 + i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_gnt", gnt, N'(1) << ((k + 1) % N));
            push((k + 1) % N, 0, 0, 0);
            @(negedge clk);
            if (k == 4) req = '0;
            #1;
            chk("t3_gap", gnt, 0);
            @(negedge clk);
        end
        drain("t3_drain");
        chk("t3_mem", mem[12], 8'h12);

        // Test 4: SWAP a=3 b=9 from requester 2 while requester 0 waits with a NOP
        @(negedge clk);
        set_cmd(2, OP_SWAP, 7'd3, 7'd9, 8'h00); set_cmd(0, OP_NOP, 7'd0, 7'd0, 8'h00);
        req = 4'b0101; #1;
        chk("t4_gnt", gnt, 4'b0100); push(2, 0, 0, 0);
        @(negedge clk); req[2] = 1'b0; #1;
        chk("t4_swap", rf_swap, 1); chk("t4_a", rf_addr_a, 3); chk("t4_b", rf_addr_b, 9);
        chk("t4_blk1", gnt, 0);
        for (int c = 2; c <= SC; c++) begin
            @(negedge clk); #1;
            chk("t4_swap_off", rf_swap, 0); chk("t4_a_hold", rf_addr_a, 3);
            chk("t4_b_hold", rf_addr_b, 9); chk("t4_blk", gnt, 0); chk("t4_busy", busy, 1);
        end
        @(negedge clk); #1;
        chk("t4_done", done, 4'b0100); chk("t4_next_gnt", gnt, 4'b0001); push(0, 0, 0, 0);
        @(negedge clk); req = '0; #1;
        chk("t4_nop_we", rf_we, 0); chk("t4_nop_swap", rf_swap, 0);
        drain("t4_drain");

        // Test 5: reset during SW_WAIT abandons the swap; requester 0 wins first afterwards
        @(negedge clk);
        set_cmd(3, OP_SWAP, 7'd1, 7'd2, 8'h00); req = 4'b1000; #1;
        chk("t5_gnt", gnt, 4'b1000); push(3, 0, 0, 0);
        @(negedge clk); req = '0;
        @(negedge clk); reset_n = 1'b0; #1;
        sb.delete();
        chk("t5_busy", busy, 0); chk("t5_swap", rf_swap, 0); chk("t5_a", rf_addr_a, 0);
        chk("t5_b", rf_addr_b, 0); chk("t5_done", done, 0); chk("t5_gnt0", gnt, 0);
        @(negedge clk); @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        set_cmd(0, OP_RD, 7'd5, 7'd0, 8'h00); set_cmd(3, OP_NOP, 7'd0, 7'd0, 8'h00);
        req = 4'b1001; #1;
        chk("t5_first", gnt, 4'b0001); push(0, 1, 8'hA5, 0);
        @(negedge clk); req[0] = 1'b0;
        @(negedge clk); #1;
        chk("t5_second", gnt, 4'b1000); push(3, 0, 0, 0);
        @(negedge clk); req = '0;
        drain("t5_drain");

        // Test 6: equal-address swap a=b=4
        @(negedge clk);
        set_cmd(1, OP_SWAP, 7'd4, 7'd4, 8'h00); req = 4'b0010; #1;
        chk("t6_gnt", gnt, 4'b0010);
`ifdef RF_ARB_ERR_EN
        push(1, 0, 0, 1);
        @(negedge clk); req = '0; #1;
        chk("t6_no_swap", rf_swap, 0);
        @(negedge clk); #1;
        chk("t6_done", done, 4'b0010); chk("t6_err", err, 1);
`else
        push(1, 0, 0, 0);
        @(negedge clk); req = '0; #1;
        chk("t6_swap", rf_swap, 1); chk("t6_a", rf_addr_a, 4); chk("t6_b", rf_addr_b, 4);
`endif
        drain("t6_drain");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
